// File: rtl/tonegen_poly.sv
// Polyphonic square-wave tone generator: per-voice dividers and timed durations,
// mixed onto one speaker pin by a first-order sigma-delta modulator.
module tonegen_poly #(
    parameter int unsigned CHANNELS  = 4,
    parameter int unsigned DIV_WIDTH = 24,
    parameter int unsigned DUR_WIDTH = 16,
    parameter int unsigned TICK_DIV  = 16000
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic [31:0]         cfg_wdata,
    input  logic [2:0]          cfg_chan,
    input  logic                cfg_we_div,
    input  logic                cfg_we_dur,
    output logic [CHANNELS-1:0] voice,
    output logic [CHANNELS-1:0] busy,
    output logic [CHANNELS-1:0] done,
    output logic                speaker
);

    localparam int unsigned TW = $clog2(TICK_DIV);
    localparam int unsigned AW = $clog2(CHANNELS) + 1;

    logic [TW-1:0] tick_cnt;
    logic          tick;
    logic          wdata_unused;

    always_comb begin
        tick         = (tick_cnt == TW'(TICK_DIV - 1));
        wdata_unused = ^cfg_wdata;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            tick_cnt <= '0;
        end else if (tick) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + 1'b1;
        end
    end

    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        logic [DIV_WIDTH-1:0] div;
        logic [DIV_WIDTH-1:0] phase;
        logic [DUR_WIDTH-1:0] dur;
        logic                 tone;
        logic                 done_r;
        logic                 sel;
        logic                 wr_div;
        logic                 wr_dur;
        logic                 expire;

        // Out-of-range cfg_chan values match no voice, so such writes are dropped.
        always_comb begin
            sel    = (cfg_chan == 3'(c));
            wr_div = cfg_we_div && sel;
            wr_dur = cfg_we_dur && sel;
            expire = tick && !wr_dur && (dur == DUR_WIDTH'(1));
        end

        always_ff @(posedge CLK or posedge RST) begin
            if (RST) begin
                dur    <= '0;
                done_r <= 1'b0;
            end else begin
                done_r <= expire;
                if (wr_dur) begin
                    dur <= cfg_wdata[DUR_WIDTH-1:0];
                end else if (tick && (dur != '0)) begin
                    dur <= dur - 1'b1;
                end
            end
        end

        // A div write takes priority over expiry; done still pulses from expire.
        always_ff @(posedge CLK or posedge RST) begin
            if (RST) begin
                div   <= '0;
                phase <= '0;
                tone  <= 1'b0;
            end else if (wr_div) begin
                div   <= cfg_wdata[DIV_WIDTH-1:0];
                phase <= '0;
                tone  <= 1'b0;
            end else if (expire) begin
                div   <= '0;
                phase <= '0;
                tone  <= 1'b0;
            end else if (div == '0) begin
                phase <= '0;
                tone  <= 1'b0;
            end else if (phase >= div) begin
                phase <= '0;
                tone  <= ~tone;
            end else begin
                phase <= phase + 1'b1;
            end
        end

        assign voice[c] = tone;
        assign busy[c]  = (dur != '0);
        assign done[c]  = done_r;
    end

    logic [AW-1:0] acc;
    logic [AW-1:0] ones;
    logic [AW-1:0] sum;

    always_comb begin
        ones = '0;
        for (int unsigned i = 0; i < CHANNELS; i++) begin
            ones = ones + AW'(voice[i]);
        end
        sum = acc + ones;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            acc     <= '0;
            speaker <= 1'b0;
        end else if (sum >= AW'(CHANNELS)) begin
            acc     <= sum - AW'(CHANNELS);
            speaker <= 1'b1;
        end else begin
            acc     <= sum;
            speaker <= 1'b0;
        end
    end

endmodule

// File: tb/tb_tonegen_poly.sv
// Self-checking bench for tonegen_poly: directed scenarios plus random writes,
// checked every cycle against a time-based reference model.
module tb_tonegen_poly;

    localparam int unsigned CH = 4;
    localparam int unsigned DW = 12;
    localparam int unsigned UW = 8;
    localparam int unsigned TD = 4;

    logic          CLK;
    logic          RST;
    logic [31:0]   cfg_wdata;
    logic [2:0]    cfg_chan;
    logic          cfg_we_div;
    logic          cfg_we_dur;
    logic [CH-1:0] voice;
    logic [CH-1:0] busy;
    logic [CH-1:0] done;
    logic          speaker;

    tonegen_poly #(
        .CHANNELS (CH),
        .DIV_WIDTH(DW),
        .DUR_WIDTH(UW),
        .TICK_DIV (TD)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .cfg_wdata (cfg_wdata),
        .cfg_chan  (cfg_chan),
        .cfg_we_div(cfg_we_div),
        .cfg_we_dur(cfg_we_dur),
        .voice     (voice),
        .busy      (busy),
        .done      (done),
        .speaker   (speaker)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // Model: edges counts clock edges since reset release; a voice written at
    // edge w with divider d is high after edge t when ((t-w)/(d+1)) is odd.
    // A timed voice expires at a precomputed edge; the mixer output follows
    // the running total of high voices crossing a multiple of CH.
    longint div_m [CH];
    longint w_m   [CH];
    longint exp_m [CH];
    bit     done_m[CH];
    longint s_m;
    longint edges;
    bit     spk_m;
    int     n_cmp;
    int     n_err;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s at edge %0d: got %0h, expected %0h", tag, edges, got, exp);
        end
    endtask

    function automatic bit voice_at(input int c, input longint t);
        if (div_m[c] == 0) return 1'b0;
        return (((t - w_m[c]) / (div_m[c] + 1)) % 2) == 1;
    endfunction

    task automatic model_reset();
        for (int c = 0; c < CH; c++) begin
            div_m[c]  = 0;
            w_m[c]    = 0;
            exp_m[c]  = -1;
            done_m[c] = 1'b0;
        end
        s_m   = 0;
        edges = 0;
        spk_m = 1'b0;
    endtask

    task automatic model_edge(input bit wd, input bit wu, input logic [2:0] ch, input logic [31:0] data);
        longint e;
        longint n;
        longint s_prev;
        longint nd;
        e = edges + 1;
        n = 0;
        for (int c = 0; c < CH; c++) n += longint'(voice_at(c, edges));
        s_prev = s_m;
        s_m    = s_m + n;
        spk_m  = (s_m / CH) != (s_prev / CH);
        for (int c = 0; c < CH; c++) begin
            done_m[c] = 1'b0;
            if (exp_m[c] == e && !(wu && int'(ch) == c)) begin
                done_m[c] = 1'b1;
                div_m[c]  = 0;
                exp_m[c]  = -1;
            end
        end
        if (int'(ch) < CH) begin
            if (wd) begin
                div_m[ch] = longint'(data[DW-1:0]);
                w_m[ch]   = e;
            end
            if (wu) begin
                nd = longint'(data[UW-1:0]);
                if (nd == 0) exp_m[ch] = -1;
                else         exp_m[ch] = TD * (e / TD + 1) + (nd - 1) * TD;
            end
        end
        edges = e;
    endtask

    task automatic compare_outputs();
        logic [CH-1:0] v_e;
        logic [CH-1:0] b_e;
        logic [CH-1:0] d_e;
        for (int c = 0; c < CH; c++) begin
            v_e[c] = voice_at(c, edges);
            b_e[c] = exp_m[c] > edges;
            d_e[c] = done_m[c];
        end
        check_val("voice",   32'(voice),   32'(v_e));
        check_val("busy",    32'(busy),    32'(b_e));
        check_val("done",    32'(done),    32'(d_e));
        check_val("speaker", 32'(speaker), 32'(spk_m));
    endtask

    // Called at a falling edge: drive, take the rising edge, check at the next falling edge.
    task automatic run_cycle(input bit wd, input bit wu, input logic [2:0] ch, input logic [31:0] data);
        cfg_we_div = wd;
        cfg_we_dur = wu;
        cfg_chan   = ch;
        cfg_wdata  = data;
        @(posedge CLK);
        model_edge(wd, wu, ch, data);
        @(negedge CLK);
        cfg_we_div = 1'b0;
        cfg_we_dur = 1'b0;
        compare_outputs();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) run_cycle(1'b0, 1'b0, 3'd0, 32'd0);
    endtask

    task automatic do_reset();
        RST = 1'b1;
        model_reset();
        #1;
        compare_outputs();
        @(posedge CLK);
        @(negedge CLK);
        compare_outputs();
        RST = 1'b0;
        model_reset();
    endtask

    initial begin
        logic [31:0] data;
        n_cmp      = 0;
        n_err      = 0;
        RST        = 1'b1;
        cfg_wdata  = '0;
        cfg_chan   = '0;
        cfg_we_div = 1'b0;
        cfg_we_dur = 1'b0;
        model_reset();
        @(negedge CLK);
        do_reset();

        // Plain tone on ch0, half-period 4
        run_cycle(1'b1, 1'b0, 3'd0, 32'd3);
        idle(20);

        // Timed voice on ch1: three ticks then silence and a single done
        run_cycle(1'b1, 1'b0, 3'd1, 32'd1);
        run_cycle(1'b0, 1'b1, 3'd1, 32'd3);
        idle(24);
        run_cycle(1'b1, 1'b0, 3'd0, 32'd0);

        // Mixer: two voices, then four voices, then none
        run_cycle(1'b1, 1'b0, 3'd0, 32'd40);
        run_cycle(1'b1, 1'b0, 3'd1, 32'd40);
        idle(90);
        for (int c = 0; c < CH; c++) run_cycle(1'b1, 1'b0, 3'(c), 32'd40);
        idle(60);
        for (int c = 0; c < CH; c++) run_cycle(1'b1, 1'b0, 3'(c), 32'd0);
        idle(10);

        // Duration rewrite landing on the tick that would expire ch2
        for (int i = 0; i < 2 * TD && ((edges + 1) % TD) != 1; i++) idle(1);
        run_cycle(1'b1, 1'b0, 3'd2, 32'd2);
        run_cycle(1'b0, 1'b1, 3'd2, 32'd1);
        for (int i = 0; i < 64 && (edges + 1) != exp_m[2]; i++) idle(1);
        check_val("dur_write_on_tick_reached", 32'((edges + 1) % TD), 32'd0);
        run_cycle(1'b0, 1'b1, 3'd2, 32'd2);
        idle(3 * TD);

        // Divider rewrite landing on the expiry edge of ch3
        run_cycle(1'b1, 1'b1, 3'd3, 32'd2);
        for (int i = 0; i < 64 && (edges + 1) != exp_m[3]; i++) idle(1);
        check_val("div_write_on_expiry_reached", 32'(busy[3]), 32'd1);
        run_cycle(1'b1, 1'b0, 3'd3, 32'd9);
        check_val("div_write_on_expiry_done", 32'(done[3]), 32'd1);
        idle(30);

        // Writes to a nonexistent channel
        for (int i = 0; i < 4; i++) begin
            data = $urandom;
            run_cycle(1'b1, 1'b1, 3'd7, data);
            run_cycle(1'b1, 1'b1, 3'(4 + i % 3), data);
        end
        idle(10);

        // Reset mid-note on two timed voices
        run_cycle(1'b1, 1'b1, 3'd0, 32'd5);
        run_cycle(1'b1, 1'b1, 3'd1, 32'd3);
        idle(7);
        do_reset();
        idle(30);

        // Random writes
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 4) == 0) begin
                data = $urandom & 32'hFFFF_F00F;
                run_cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                          3'($urandom_range(0, 7)), data);
            end else begin
                idle(1);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
